// File: rtl/serial_bit_source.sv
// Serial stimulus source: debounced key steps a captured pattern out MSB first.
// Optional SERIAL_SRC_LOOP_EN: wrap to the last loaded pattern instead of DONE.
module serial_bit_source #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             key_n,
  input  logic             load,
  input  logic [WIDTH-1:0] pattern,
  output logic             w,
  output logic             step,
  output logic [3:0]       bit_idx,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]       LAST    = 4'(WIDTH - 1);

  state_t           state;
  logic             sync1;
  logic             sync2;
  logic             stable;
  logic             stable_d;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] sr;
  logic             press;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      stable   <= 1'b1;
      stable_d <= 1'b1;
      cnt      <= '0;
    end else begin
      sync1    <= key_n;
      sync2    <= sync1;
      stable_d <= stable;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Key is active-low: a press is the accepted fall of the stable level
  assign press = stable_d & ~stable;

`ifdef SERIAL_SRC_LOOP_EN
  logic [WIDTH-1:0] held;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      held <= '0;
    end else if (load) begin
      held <= pattern;
    end
  end
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      sr      <= '0;
      bit_idx <= '0;
      w       <= 1'b0;
      step    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          step <= 1'b0;
          if (load) begin
            state   <= SHIFT;
            sr      <= pattern;
            bit_idx <= '0;
            w       <= pattern[WIDTH-1];
            busy    <= 1'b1;
            done    <= 1'b0;
          end
        end
        SHIFT: begin
          done <= 1'b0;
          if (load) begin
            sr      <= pattern;
            bit_idx <= '0;
            w       <= pattern[WIDTH-1];
            step    <= 1'b0;
          end else if (step) begin
            if (bit_idx == LAST) begin
`ifdef SERIAL_SRC_LOOP_EN
              sr      <= held;
              bit_idx <= '0;
              w       <= held[WIDTH-1];
              done    <= 1'b1;
              step    <= press;
`else
              state   <= DONE;
              sr      <= sr << 1;
              bit_idx <= bit_idx + 1'b1;
              w       <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
              step    <= 1'b0;
`endif
            end else begin
              sr      <= sr << 1;
              bit_idx <= bit_idx + 1'b1;
              w       <= sr[WIDTH-2];
              step    <= press;
            end
          end else begin
            step <= press;
          end
        end
        default: begin
          state <= IDLE;
          step  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_bit_source.sv
// Bench for serial_bit_source: vector table, corner sequences, random vs model.
// Build with SERIAL_SRC_LOOP_EN defined to exercise the wrap mode.
module tb_serial_bit_source;

  logic       clock = 1'b0;
  logic       resetn;
  logic       key_n;
  logic       load;
  logic [7:0] pattern;
  logic       w;
  logic       step;
  logic [3:0] bit_idx;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;
  int nsteps = 0;
  int done_cyc = 0;
  logic last_w = 1'b0;

  always #5 clock = ~clock;

  serial_bit_source #(
    .WIDTH(8),
    .DEBOUNCE_CYCLES(4),
    .CNT_W(3)
  ) dut (
    .clock(clock),
    .resetn(resetn),
    .key_n(key_n),
    .load(load),
    .pattern(pattern),
    .w(w),
    .step(step),
    .bit_idx(bit_idx),
    .busy(busy),
    .done(done)
  );

  always @(negedge clock) begin
    if (resetn === 1'b1) begin
      if (step === 1'b1) begin
        nsteps++;
        last_w = w;
      end
      if (done === 1'b1) done_cyc++;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string name, input int ew, input int ei,
                          input int eb, input int ed);
    chk({name, ".w"}, int'(w), ew);
    chk({name, ".bit_idx"}, int'(bit_idx), ei);
    chk({name, ".busy"}, int'(busy), eb);
    chk({name, ".done"}, int'(done), ed);
  endtask

  task automatic do_press();
    @(negedge clock) key_n = 1'b0;
    repeat (12) @(negedge clock);
    key_n = 1'b1;
    repeat (12) @(negedge clock);
  endtask

  task automatic do_load(input logic [7:0] p);
    @(negedge clock);
    load    = 1'b1;
    pattern = p;
    @(negedge clock) load = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  typedef struct {
    bit         is_load;
    logic [7:0] pat;
    int         exp_steps;
    int         exp_sw;
    int         exp_w;
    int         exp_idx;
    int         exp_busy;
    int         exp_done;
  } vec_t;

  vec_t tbl[11];

  // High-level model: pattern, consumed count and phase flags
  bit         m_shift;
  bit         m_done;
  logic [7:0] m_pat;
  int         m_idx;

  initial begin
    int s0;
    int d0;
    int lat;
    int wraps;
    int exp_sw;
    logic [7:0] p;
    int loop_exp[10];

    tbl[0] = '{1'b1, 8'hD6, 0, 0, 1, 0, 1, 0};
    tbl[1] = '{1'b0, 8'h00, 1, 1, 1, 1, 1, 0};
    tbl[2] = '{1'b0, 8'h00, 1, 1, 0, 2, 1, 0};
    tbl[3] = '{1'b0, 8'h00, 1, 0, 1, 3, 1, 0};
    tbl[4] = '{1'b0, 8'h00, 1, 1, 0, 4, 1, 0};
    tbl[5] = '{1'b0, 8'h00, 1, 0, 1, 5, 1, 0};
    tbl[6] = '{1'b0, 8'h00, 1, 1, 1, 6, 1, 0};
    tbl[7] = '{1'b0, 8'h00, 1, 1, 0, 7, 1, 0};
`ifdef SERIAL_SRC_LOOP_EN
    tbl[8] = '{1'b0, 8'h00, 1, 0, 1, 0, 1, 0};
    tbl[9] = '{1'b0, 8'h00, 1, 1, 1, 1, 1, 0};
`else
    tbl[8] = '{1'b0, 8'h00, 1, 0, 0, 8, 0, 1};
    tbl[9] = '{1'b0, 8'h00, 0, 0, 0, 8, 0, 1};
`endif
    tbl[10] = '{1'b1, 8'hFF, 0, 0, 1, 0, 1, 0};

    // Reset with key held low and load held high
    resetn  = 1'b0;
    key_n   = 1'b0;
    load    = 1'b1;
    pattern = 8'hD6;
    #3;
    chk("rst_async.step", int'(step), 0);
    chk_outs("rst_async", 0, 0, 0, 0);
    repeat (3) @(negedge clock);
    chk("rst_hold.step", int'(step), 0);
    chk_outs("rst_hold", 0, 0, 0, 0);
    resetn = 1'b1;
    repeat (15) @(negedge clock);
    chk("rst_loadheld.steps", nsteps, 0);
    chk_outs("rst_loadheld", 1, 0, 1, 0);
    load  = 1'b0;
    key_n = 1'b1;
    repeat (15) @(negedge clock);
    chk("rst_release.steps", nsteps, 0);

    // Vector table
    for (int i = 0; i < 11; i++) begin
      s0 = nsteps;
      if (tbl[i].is_load) do_load(tbl[i].pat);
      else do_press();
      chk($sformatf("vec%0d.steps", i), nsteps - s0, tbl[i].exp_steps);
      if (tbl[i].exp_steps > 0)
        chk($sformatf("vec%0d.step_w", i), int'(last_w), tbl[i].exp_sw);
      chk_outs($sformatf("vec%0d", i), tbl[i].exp_w, tbl[i].exp_idx,
               tbl[i].exp_busy, tbl[i].exp_done);
    end

    // Asynchronous reset in mid-run, before any further clock edge
    @(negedge clock);
    #2 resetn = 1'b0;
    #1;
    chk_outs("async_mid", 0, 0, 0, 0);
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    repeat (2) @(negedge clock);

    // Bounce of short low pulses, then a long hold: one step, fixed latency
    do_load(8'hD6);
    s0 = nsteps;
    repeat (3) begin
      key_n = 1'b0;
      repeat (3) @(negedge clock);
      key_n = 1'b1;
      repeat (3) @(negedge clock);
    end
    key_n = 1'b0;
    lat   = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clock);
      if (step === 1'b1 && lat == 0) lat = n;
    end
    key_n = 1'b1;
    repeat (12) @(negedge clock);
    chk("bounce.latency", lat, 7);
    chk("bounce.steps", nsteps - s0, 1);
    chk("bounce.step_w", int'(last_w), 1);
    chk_outs("bounce", 1, 1, 1, 0);

    // Load coinciding with a press at bit_idx=3
    do_load(8'hD6);
    repeat (3) do_press();
    chk("coinc.pre_idx", int'(bit_idx), 3);
    s0 = nsteps;
    @(negedge clock) key_n = 1'b0;
    repeat (5) @(negedge clock);
    load    = 1'b1;
    pattern = 8'h2B;
    repeat (2) @(negedge clock);
    load = 1'b0;
    repeat (6) @(negedge clock);
    key_n = 1'b1;
    repeat (12) @(negedge clock);
    chk("coinc.steps", nsteps - s0, 0);
    chk_outs("coinc", 0, 0, 1, 0);
    s0 = nsteps;
    do_press();
    chk("coinc_next.steps", nsteps - s0, 1);
    chk("coinc_next.step_w", int'(last_w), 0);
    chk_outs("coinc_next", 0, 1, 1, 0);

`ifdef SERIAL_SRC_LOOP_EN
    // Wrap mode: 10 presses on A5
    loop_exp = '{1, 0, 1, 0, 0, 1, 0, 1, 1, 0};
    do_load(8'hA5);
    d0 = done_cyc;
    for (int i = 0; i < 10; i++) begin
      s0 = nsteps;
      do_press();
      chk($sformatf("loop%0d.steps", i), nsteps - s0, 1);
      chk($sformatf("loop%0d.step_w", i), int'(last_w), loop_exp[i]);
    end
    chk("loop.done_pulse", done_cyc - d0, 1);
    chk_outs("loop.end", 1, 2, 1, 0);
`endif

    // Random operations against the model
    p = 8'($urandom);
    do_load(p);
    m_pat   = p;
    m_idx   = 0;
    m_shift = 1'b1;
    m_done  = 1'b0;
    for (int i = 0; i < 30; i++) begin
      s0    = nsteps;
      d0    = done_cyc;
      wraps = 0;
      exp_sw = -1;
      if ($urandom_range(3) == 0) begin
        p = 8'($urandom);
        do_load(p);
        m_pat   = p;
        m_idx   = 0;
        m_shift = 1'b1;
        m_done  = 1'b0;
      end else begin
        do_press();
        if (m_shift) begin
          exp_sw = int'(m_pat[7-m_idx]);
          m_idx++;
          if (m_idx == 8) begin
`ifdef SERIAL_SRC_LOOP_EN
            m_idx = 0;
            wraps = 1;
`else
            m_shift = 1'b0;
            m_done  = 1'b1;
`endif
          end
        end
      end
      chk($sformatf("rnd%0d.steps", i), nsteps - s0, (exp_sw >= 0) ? 1 : 0);
      if (exp_sw >= 0)
        chk($sformatf("rnd%0d.step_w", i), int'(last_w), exp_sw);
`ifdef SERIAL_SRC_LOOP_EN
      chk($sformatf("rnd%0d.done_pulse", i), done_cyc - d0, wraps);
`endif
      chk_outs($sformatf("rnd%0d", i),
               m_shift ? int'(m_pat[7-m_idx]) : 0,
               m_idx, int'(m_shift), int'(m_done));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
